map_seq_gen: RTL and testbench
==============================

MAP_SEQ_GEN -- requirements
Module: map_seq_gen

Interface
REQ-001 Parameter SR_W, default 8: LFSR width.
REQ-002 Parameter CNT_W, default 8: down-counter width.
REQ-003 Parameter N_W, default CNT_W+1: width of n.
REQ-004 Parameter DP_W, default SR_W+1: width of dp.
REQ-005 Parameter TAPS, default 8'hB8: feedback tap mask, SR_W bits wide.
REQ-006 Parameter SEED, default 0: LFSR value loaded at run start, SR_W bits wide.
REQ-007 clock  in  1  sole clock; every flop updates on its rising edge.
REQ-008 reset  in  1  synchronous reset, active-high.
REQ-009 start  in  1  asynchronous request; a rising edge launches a run.
REQ-010 n  in  N_W  run descriptor: n[N_W-1:1] is the shift count, n[0] is the dp LSB.
REQ-011 abort  in  1  synchronous cancel of a run in progress; present only under MAP_SEQ_ABORT_EN.
REQ-012 busy  out  1  high in RUN and LOAD.
REQ-013 done  out  1  sticky run-complete flag.
REQ-014 dp  out  DP_W  result register.
REQ-015 counter  out  CNT_W  live down-counter.
REQ-016 sr  out  SR_W  live LFSR state.

Function
REQ-017 start SHALL pass through a 2-flop synchroniser s0->s1; edge = s0 & ~s1.
REQ-018 The FSM SHALL have four states: IDLE, RUN, LOAD, DONE.
REQ-019 In IDLE, when edge=1: counter <= n[CNT_W:1], sr <= SEED, done <= 0, next state RUN.
REQ-020 In RUN with counter != 0: sr <= {sr[SR_W-2:0], fb}, fb = ~^(sr & TAPS); counter <= counter-1.
REQ-021 In RUN with counter == 0: no shift, next state LOAD; a run loaded with count 0 therefore performs zero shifts.
REQ-022 In LOAD: dp <= {sr, n[0]}, done <= 1, next state DONE.
REQ-023 DONE SHALL go to IDLE on the next cycle unconditionally.
REQ-024 done SHALL stay high until the next accepted edge or reset.
REQ-025 dp SHALL hold its value between LOAD events.
REQ-026 Latency: dp and done SHALL update on rising edge C+4, counting from the edge that first samples start=1, where C = n[CNT_W:1].
REQ-027 An edge occurring in RUN, LOAD or DONE SHALL be ignored and not queued.
REQ-028 n SHALL be sampled only in IDLE on an edge (counter load) and in LOAD (n[0]); n changing mid-run SHALL not affect counter or sr.
REQ-029 abort=1 in RUN SHALL return the FSM to IDLE next cycle, leave dp unchanged and keep done=0.
REQ-030 abort SHALL be ignored in every state other than RUN; abort and counter==0 on the same cycle SHALL take the abort path.
REQ-031 The all-ones sr value is the XNOR-LFSR lock-up state; it SHALL not be special-cased.

Reset
REQ-032 With reset=1 at a clock edge: FSM <= IDLE, s0, s1, counter, sr, dp, done <= 0; busy SHALL read 0 on the next cycle.
REQ-033 Reset asserted mid-run SHALL discard the run without producing a done pulse.
REQ-034 A start level that is high when reset deasserts SHALL generate an edge, since s1 resets to 0.

Configuration
REQ-035 Macro MAP_SEQ_ABORT_EN defined: the abort port exists and REQ-029 and REQ-030 apply.
REQ-036 Macro MAP_SEQ_ABORT_EN undefined: no abort port; RUN exits only when counter reaches 0.

Structure
REQ-037 Package map_seq_pkg SHALL hold the state enum (IDLE, RUN, LOAD, DONE), DEFAULT_TAPS = 8'hB8 and DEFAULT_SEED = 0.
REQ-038 Sub-module start_edge_sync SHALL contain the synchroniser and edge detector; the LFSR and counter stay in map_seq_gen.

Verification
REQ-039 Defaults, SEED=0, n=9'd6, pulse start: sr steps 0x01, 0x03, 0x07; dp=9'h00E; done rises at edge 7.
REQ-040 n=9'd1 (C=0): zero shifts; dp=9'h001, done at edge 4; repeat with n=9'd0: dp=9'h000.
REQ-041 n=9'd12 (C=6): sr sequence 01, 03, 07, 0F, 1E, 3D; dp=9'h07A.
REQ-042 Second start pulse during RUN: ignored; a single done; dp matches the one-run value.
REQ-043 Under MAP_SEQ_ABORT_EN, abort in the 2nd RUN cycle of n=9'd12: IDLE next cycle; dp keeps its prior value; done=0; busy=0.
REQ-044 Reset in the 3rd RUN cycle: all outputs 0 next cycle; no done pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/map_seq_pkg.sv
// ---------------------------------------------------------------------------
// map_seq_pkg
// Shared definitions for the map_seq_gen block.
//   state_e       : FSM states of the run sequencer (IDLE, RUN, LOAD, DONE)
//   DEFAULT_TAPS  : default XNOR-LFSR feedback mask (8'hB8)
//   DEFAULT_SEED  : default LFSR value loaded when a run starts
// Optional feature macro used by the block: MAP_SEQ_ABORT_EN.
// ---------------------------------------------------------------------------
package map_seq_pkg;

  // IDLE is encoded as zero so that a reset register bank reads as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h00;

endpackage : map_seq_pkg

// File: rtl/map_seq_gen_start_edge_sync.sv
// ---------------------------------------------------------------------------
// start_edge_sync
// Brings the asynchronous start request into the clock domain with a
// two-flop synchroniser (s0 -> s1) and flags its rising edge.
// Ports:
//   clock      in  sole clock, rising edge
//   reset      in  synchronous, active-high; clears both flops
//   start      in  asynchronous start level
//   start_edge out one-cycle pulse, s0 & ~s1
// Because s1 resets to 0, a start level already high when reset releases
// produces an edge.
// ---------------------------------------------------------------------------
module start_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic start_edge
);

  logic s0_q;
  logic s1_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= start;
      s1_q <= s0_q;
    end
  end

  assign start_edge = s0_q & ~s1_q;

endmodule : start_edge_sync

// File: rtl/map_seq_gen.sv
// ---------------------------------------------------------------------------
// map_seq_gen
// Run sequencer: a start edge loads a down-counter from n[CNT_W:1] and the
// LFSR from SEED, the LFSR shifts once per cycle until the counter hits
// zero, then {sr, n[0]} is captured into dp and the sticky done flag rises.
//
// Optional feature (macro MAP_SEQ_ABORT_EN): adds the abort input, which
// cancels a run while in RUN without touching dp or done.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   asynchronous run request (rising edge launches a run)
//   n          in   N_W  run descriptor: n[N_W-1:1] shift count, n[0] dp LSB
//   abort      in   cancel in RUN (only with MAP_SEQ_ABORT_EN)
//   busy       out  high while in RUN or LOAD
//   done       out  sticky run-complete flag
//   dp         out  DP_W result register
//   counter    out  CNT_W live down-counter
//   sr         out  SR_W live LFSR state
//   state_dbg  out  2-bit FSM state (state_e encoding) for observation
//
// Handshake: start is a level sampled through a synchroniser; only its rising
// edge matters, and an edge seen outside IDLE is dropped, never queued.
// ---------------------------------------------------------------------------
module map_seq_gen
  import map_seq_pkg::*;
#(
  parameter int              SR_W  = 8,
  parameter int              CNT_W = 8,
  parameter int              N_W   = CNT_W + 1,
  parameter int              DP_W  = SR_W + 1,
  parameter logic [SR_W-1:0] TAPS  = SR_W'(DEFAULT_TAPS),
  parameter logic [SR_W-1:0] SEED  = SR_W'(DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N_W-1:0]   n,
`ifdef MAP_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [DP_W-1:0]  dp,
  output logic [CNT_W-1:0] counter,
  output logic [SR_W-1:0]  sr,
  output logic [1:0]       state_dbg
);

  // -------------------------------------------------------------------------
  // Start synchronisation
  // -------------------------------------------------------------------------
  logic start_edge;

  start_edge_sync u_start_edge_sync (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_edge (start_edge)
  );

  // -------------------------------------------------------------------------
  // Optional abort
  // -------------------------------------------------------------------------
  logic abort_req;

`ifdef MAP_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e             state_q;
  logic [CNT_W-1:0]   counter_q;
  logic [SR_W-1:0]    sr_q;
  logic [DP_W-1:0]    dp_q;
  logic               done_q;
  logic               busy_q;

  // XNOR feedback: the all-ones state is a lock-up point and is left as-is;
  // from the zero seed the sequence never reaches it.
  logic               fb_d;
  logic [SR_W-1:0]    sr_d;

  assign fb_d = ~^(sr_q & TAPS);
  assign sr_d = {sr_q[SR_W-2:0], fb_d};

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      sr_q      <= '0;
      dp_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            counter_q <= n[CNT_W:1];
            sr_q      <= SEED;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end

        RUN: begin
          // Abort wins over the counter-zero exit when both happen together.
          if (abort_req) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (counter_q != '0) begin
            sr_q      <= sr_d;
            counter_q <= counter_q - CNT_W'(1);
          end else begin
            state_q <= LOAD;
          end
        end

        LOAD: begin
          // n[0] is sampled here, not at run start.
          dp_q    <= DP_W'({sr_q, n[0]});
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy      = busy_q;
  assign done      = done_q;
  assign dp        = dp_q;
  assign counter   = counter_q;
  assign sr        = sr_q;
  assign state_dbg = state_q;

endmodule : map_seq_gen

// File: tb/tb_map_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_map_seq_gen
// Self-checking bench for map_seq_gen with default parameters. Expected
// results come from a transaction-level model: the final dp of a run is
// SEED stepped C times by the LFSR rule with n[0] appended, and done rises
// on edge C+4 counting the edge that first samples start as edge 1.
// ---------------------------------------------------------------------------
module tb_map_seq_gen;
  import map_seq_pkg::*;

  localparam logic [7:0] MODEL_TAPS = 8'hB8;
  localparam logic [7:0] MODEL_SEED = 8'h00;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [8:0] n = 9'd0;
`ifdef MAP_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  logic       busy;
  logic       done;
  logic [8:0] dp;
  logic [7:0] counter;
  logic [7:0] sr;
  logic [1:0] state_dbg;

  always #5 clock = ~clock;

  map_seq_gen dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .n         (n),
`ifdef MAP_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .dp        (dp),
    .counter   (counter),
    .sr        (sr),
    .state_dbg (state_dbg)
  );

  // Scoreboard
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [8:0] exp_q[$];
  logic [7:0] sr_seen_q[$];

  // Reference model
  function automatic logic [7:0] model_sr(input int steps);
    logic [7:0] s;
    s = MODEL_SEED;
    for (int i = 0; i < steps; i++) s = {s[6:0], ~^(s & MODEL_TAPS)};
    return s;
  endfunction

  function automatic logic [8:0] model_dp(input logic [8:0] nv, input logic lsb);
    return {model_sr(int'(nv[8:1])), lsb};
  endfunction

  // Driver: pulses start with descriptor nv, optionally changes n to n_mid
  // after the load edge and re-pulses start at edge repulse_at. Returns the
  // edge number at which done was first seen (0 if the bound expired) and
  // records sr after each edge from 2 to C+2 in sr_seen_q.
  task automatic do_run(input logic [8:0] nv, input logic [8:0] n_mid,
                        input int repulse_at, output int lat);
    int c;
    c   = int'(nv[8:1]);
    lat = 0;
    sr_seen_q = {};
    @(negedge clock);
    n     = nv;
    start = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 2) n = n_mid;
      if (repulse_at != 0 && k == repulse_at) start = 1'b1;
      if (repulse_at != 0 && k == repulse_at + 1) start = 1'b0;
      if (k >= 2 && k <= c + 2) sr_seen_q.push_back(sr);
      if (k >= 2 && done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (dp !== 9'h000) begin n_mis++; $display("FAIL reset_dp: got %h want 000", dp); end
    n_cmp++; if (counter !== 8'h00) begin n_mis++; $display("FAIL reset_counter: got %h want 00", counter); end
    n_cmp++; if (sr !== 8'h00) begin n_mis++; $display("FAIL reset_sr: got %h want 00", sr); end
    n_cmp++; if (state_dbg !== 2'(IDLE)) begin n_mis++; $display("FAIL reset_state: got %0d want %0d", state_dbg, 2'(IDLE)); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Start held high across reset release must still launch a run.
  task automatic test_start_held_reset();
    int lat;
    lat   = 0;
    reset = 1'b1;
    start = 1'b1;
    n     = 9'd6;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k >= 2 && done === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_cmp++; if (lat != 7) begin n_mis++; $display("FAIL held_start_latency: got %0d want 7", lat); end
    n_cmp++; if (dp !== 9'h00E) begin n_mis++; $display("FAIL held_start_dp: got %h want 00e", dp); end
  endtask

  // Directed vectors with hand-computed results.
  task automatic test_vectors();
    logic [8:0] tv_n[4]   = '{9'd6, 9'd1, 9'd0, 9'd12};
    logic [8:0] tv_dp[4]  = '{9'h00E, 9'h001, 9'h000, 9'h07A};
    int         tv_lat[4] = '{7, 4, 4, 10};
    int lat;
    for (int t = 0; t < 4; t++) begin
      do_run(tv_n[t], tv_n[t], 0, lat);
      n_cmp++; if (lat != tv_lat[t]) begin n_mis++; $display("FAIL vec%0d_latency: got %0d want %0d", t, lat, tv_lat[t]); end
      n_cmp++; if (dp !== tv_dp[t]) begin n_mis++; $display("FAIL vec%0d_dp: got %h want %h", t, dp, tv_dp[t]); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL vec%0d_busy: got %b want 0", t, busy); end
      for (int i = 0; i < sr_seen_q.size(); i++) begin
        n_cmp++; if (sr_seen_q[i] !== model_sr(i)) begin n_mis++; $display("FAIL vec%0d_sr[%0d]: got %h want %h", t, i, sr_seen_q[i], model_sr(i)); end
      end
    end
  endtask

  // Random descriptors, plus the largest shift count.
  task automatic test_random();
    logic [8:0] nv;
    logic [8:0] exp_dp;
    int lat;
    for (int t = 0; t < 11; t++) begin
      nv = (t == 10) ? 9'h1FF : 9'($urandom_range(0, 80));
      exp_q.push_back(model_dp(nv, nv[0]));
      do_run(nv, nv, 0, lat);
      exp_dp = exp_q.pop_front();
      n_cmp++; if (lat != int'(nv[8:1]) + 4) begin n_mis++; $display("FAIL rand%0d_latency n=%h: got %0d want %0d", t, nv, lat, int'(nv[8:1]) + 4); end
      n_cmp++; if (dp !== exp_dp) begin n_mis++; $display("FAIL rand%0d_dp n=%h: got %h want %h", t, nv, dp, exp_dp); end
      n_cmp++; if (sr_seen_q.size() != int'(nv[8:1]) + 1) begin n_mis++; $display("FAIL rand%0d_sr_count: got %0d want %0d", t, sr_seen_q.size(), int'(nv[8:1]) + 1); end
      for (int i = 0; i < sr_seen_q.size(); i++) begin
        n_cmp++; if (sr_seen_q[i] !== model_sr(i)) begin n_mis++; $display("FAIL rand%0d_sr[%0d]: got %h want %h", t, i, sr_seen_q[i], model_sr(i)); end
      end
    end
  endtask

  // Count bits of n changing mid-run are ignored; n[0] is taken in LOAD.
  task automatic test_n_change();
    logic [8:0] n_mid;
    int lat;
    n_mid = {8'($urandom_range(0, 255)), 1'b0};
    do_run(9'd12, n_mid, 0, lat);
    n_cmp++; if (lat != 10) begin n_mis++; $display("FAIL nchg_latency: got %0d want 10", lat); end
    n_cmp++; if (dp !== 9'h07A) begin n_mis++; $display("FAIL nchg_dp n_mid=%h: got %h want 07a", n_mid, dp); end
    do_run(9'd12, 9'h1FF, 0, lat);
    n_cmp++; if (lat != 10) begin n_mis++; $display("FAIL nchg_lsb_latency: got %0d want 10", lat); end
    n_cmp++; if (dp !== 9'h07B) begin n_mis++; $display("FAIL nchg_lsb_dp: got %h want 07b", dp); end
  endtask

  // A second start edge during RUN is dropped, not queued.
  task automatic test_back_to_back();
    int lat;
    do_run(9'd12, 9'd12, 4, lat);
    n_cmp++; if (lat != 10) begin n_mis++; $display("FAIL b2b_latency: got %0d want 10", lat); end
    n_cmp++; if (dp !== 9'h07A) begin n_mis++; $display("FAIL b2b_dp: got %h want 07a", dp); end
    repeat (12) @(negedge clock);
    n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL b2b_done_sticky: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL b2b_no_rerun: got busy %b want 0", busy); end
    n_cmp++; if (dp !== 9'h07A) begin n_mis++; $display("FAIL b2b_dp_hold: got %h want 07a", dp); end
  endtask

  // Reset during the 3rd RUN cycle discards the run.
  task automatic test_midrun_reset();
    logic saw_done;
    int lat;
    saw_done = 1'b0;
    @(negedge clock);
    n     = 9'd12;
    start = 1'b1;
    @(negedge clock);   // after edge 1
    start = 1'b0;
    repeat (3) @(negedge clock);   // after edge 4: third RUN cycle
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL mrst_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL mrst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL mrst_done: got %b want 0", done); end
    n_cmp++; if (dp !== 9'h000) begin n_mis++; $display("FAIL mrst_dp: got %h want 000", dp); end
    n_cmp++; if (counter !== 8'h00) begin n_mis++; $display("FAIL mrst_counter: got %h want 00", counter); end
    n_cmp++; if (sr !== 8'h00) begin n_mis++; $display("FAIL mrst_sr: got %h want 00", sr); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_mis++; $display("FAIL mrst_no_done: got %b want 0", saw_done); end
    do_run(9'd12, 9'd12, 0, lat);
    n_cmp++; if (lat != 10) begin n_mis++; $display("FAIL mrst_rerun_latency: got %0d want 10", lat); end
    n_cmp++; if (dp !== 9'h07A) begin n_mis++; $display("FAIL mrst_rerun_dp: got %h want 07a", dp); end
  endtask

`ifdef MAP_SEQ_ABORT_EN
  // Abort in RUN: back to IDLE, dp kept, done stays low. Also abort on the
  // cycle where the counter is already zero.
  task automatic test_abort();
    logic [8:0] ab_n[2]   = '{9'd12, 9'd1};
    int         ab_at[2]  = '{3, 2};
    logic saw_done;
    int lat;
    for (int t = 0; t < 2; t++) begin
      do_run(9'd6, 9'd6, 0, lat);
      n_cmp++; if (dp !== 9'h00E) begin n_mis++; $display("FAIL abort%0d_pre_dp: got %h want 00e", t, dp); end
      @(negedge clock);
      n     = ab_n[t];
      start = 1'b1;
      for (int k = 1; k <= ab_at[t]; k++) begin
        @(negedge clock);
        if (k == 1) start = 1'b0;
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL abort%0d_busy: got %b want 0", t, busy); end
      n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL abort%0d_done: got %b want 0", t, done); end
      n_cmp++; if (state_dbg !== 2'(IDLE)) begin n_mis++; $display("FAIL abort%0d_state: got %0d want %0d", t, state_dbg, 2'(IDLE)); end
      saw_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        if (done === 1'b1) saw_done = 1'b1;
      end
      n_cmp++; if (saw_done !== 1'b0) begin n_mis++; $display("FAIL abort%0d_no_done: got %b want 0", t, saw_done); end
      n_cmp++; if (dp !== 9'h00E) begin n_mis++; $display("FAIL abort%0d_dp_hold: got %h want 00e", t, dp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_held_reset();
    test_vectors();
    test_random();
    test_n_change();
    test_back_to_back();
    test_midrun_reset();
`ifdef MAP_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule : tb_map_seq_gen
